// File: rtl/conv_8b_32b.sv
// Byte-to-word deserializer: packs LANES DATA_W-bit beats (MSB lane first) into one word.
// Optional mid-word drop flag err_partial is built when CONV_8B_32B_ERR_EN is defined.
//
//   state  | meaning
//   S_IDLE | no beats collected, cnt == 0, accumulator empty
//   S_ACC  | 1..LANES-1 beats collected, waiting for the rest of the word
module conv_8b_32b #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4
) (
   input  logic                     clk_4f,
   input  logic                     reset_L,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     valid_in,
   output logic [DATA_W*LANES-1:0]  data_out,
   output logic                     valid_out,
   output logic                     word_done
`ifdef CONV_8B_32B_ERR_EN
   ,
   output logic                     err_partial
`endif
);

   localparam int WORD_W = DATA_W * LANES;
   localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACC  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [CNT_W-1:0]  w_lane;
   logic [WORD_W-1:0] r_acc;
   logic [WORD_W-1:0] w_acc_nxt;
   logic [WORD_W-1:0] r_data;
   logic [WORD_W-1:0] w_data_nxt;
   logic              r_valid;
   logic              w_valid_nxt;
   logic              r_done;
   logic              w_done_nxt;
   logic              w_drop;

   assign w_lane = LAST_LANE - r_cnt;

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_acc   <= w_acc_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_acc_nxt   = r_acc;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_done_nxt  = 1'b0;
      w_drop      = 1'b0;
      if (valid_in) begin
         if (r_cnt == LAST_LANE) begin
            // The final beat goes straight into the output word, never through acc.
            w_data_nxt  = {r_acc[WORD_W-1:DATA_W], data_in};
            w_valid_nxt = 1'b1;
            w_done_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_acc_nxt   = '0;
            w_state_nxt = S_IDLE;
         end else begin
            w_acc_nxt[w_lane*DATA_W +: DATA_W] = data_in;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = S_ACC;
         end
      end else begin
         w_valid_nxt = 1'b0;
         w_cnt_nxt   = '0;
         w_acc_nxt   = '0;
         w_state_nxt = S_IDLE;
         w_drop      = (r_state == S_ACC);
      end
   end

   assign data_out  = r_data;
   assign valid_out = r_valid;
   assign word_done = r_done;

`ifdef CONV_8B_32B_ERR_EN
   logic r_err;

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_drop;
      end
   end

   assign err_partial = r_err;
`else
   logic w_drop_unused;
   assign w_drop_unused = w_drop;
`endif

endmodule

// File: tb/tb_conv_8b_32b.sv
// Self-checking bench for conv_8b_32b: directed scenarios plus random beats,
// compared every cycle against a queue-based word assembly model.
module tb_conv_8b_32b;
   localparam int DATA_W = 8;
   localparam int LANES  = 4;
   localparam int WORD_W = DATA_W * LANES;

   logic              clk_4f = 1'b0;
   logic              reset_L = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic              valid_in = 1'b0;
   logic [WORD_W-1:0] data_out;
   logic              valid_out;
   logic              word_done;
`ifdef CONV_8B_32B_ERR_EN
   logic              err_partial;
`endif

   conv_8b_32b #(.DATA_W(DATA_W), .LANES(LANES)) dut (
      .clk_4f     (clk_4f),
      .reset_L    (reset_L),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .word_done  (word_done)
`ifdef CONV_8B_32B_ERR_EN
      ,
      .err_partial(err_partial)
`endif
   );

   always #5 clk_4f = ~clk_4f;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: beats of the current run kept in a queue, a word emitted when full.
   logic [DATA_W-1:0] m_beats[$];
   logic [WORD_W-1:0] m_word = '0;
   bit                m_vo = 0, m_wd = 0, m_err = 0;
   logic [WORD_W-1:0] words_out[$];
   int                wd_cycles[$];
   int                cyc = 0;

   always @(posedge clk_4f) begin
      cyc++;
      if (!reset_L) begin
         m_beats.delete();
         m_word = '0; m_vo = 0; m_wd = 0; m_err = 0;
      end else begin
         m_wd = 0; m_err = 0;
         if (valid_in) begin
            m_beats.push_back(data_in);
            if (m_beats.size() == LANES) begin
               m_word = '0;
               foreach (m_beats[i]) m_word = (m_word << DATA_W) | WORD_W'(m_beats[i]);
               m_beats.delete();
               m_vo = 1; m_wd = 1;
               words_out.push_back(m_word);
               wd_cycles.push_back(cyc);
            end
         end else begin
            if (m_beats.size() != 0) m_err = 1;
            m_beats.delete();
            m_vo = 0;
         end
      end
      #1;
      check("data_out",  64'(data_out),  64'(m_word));
      check("valid_out", 64'(valid_out), 64'(m_vo));
      check("word_done", 64'(word_done), 64'(m_wd));
`ifdef CONV_8B_32B_ERR_EN
      check("err_partial", 64'(err_partial), 64'(m_err));
      if (err_partial && word_done) check("err_with_done", 64'(1), 64'(0));
`endif
   end

   task automatic beat(input bit v, input logic [DATA_W-1:0] d);
      @(negedge clk_4f);
      valid_in = v;
      data_in  = d;
      @(posedge clk_4f);
      #2;
   endtask

   task automatic send_word(input logic [WORD_W-1:0] w);
      for (int i = LANES - 1; i >= 0; i--) beat(1'b1, w[i*DATA_W +: DATA_W]);
   endtask

   initial begin
      // T1: reset then one word
      #3;
      check("reset_data_out", 64'(data_out), 64'(0));
      check("reset_valid_out", 64'(valid_out), 64'(0));
      check("reset_word_done", 64'(word_done), 64'(0));
      @(negedge clk_4f); @(negedge clk_4f);
      reset_L = 1'b1;
      beat(1, 8'hAA); beat(1, 8'hBB); beat(1, 8'hCC);
      check("t1_no_early_done", 64'(word_done), 64'(0));
      beat(1, 8'hDD);
      check("t1_word", 64'(data_out), 64'(32'hAABBCCDD));
      check("t1_valid", 64'(valid_out), 64'(1));
      check("t1_done", 64'(word_done), 64'(1));
      beat(0, 8'h00);
      check("t1_done_pulse", 64'(word_done), 64'(0));

      // T2: back-to-back words
      wd_cycles.delete();
      for (int i = 1; i <= 8; i++) begin
         beat(1, 8'(i));
         if (i > 4) check("t2_valid_held", 64'(valid_out), 64'(1));
      end
      check("t2_word2", 64'(data_out), 64'(32'h05060708));
      check("t2_two_words", 64'(wd_cycles.size()), 64'(2));
      if (wd_cycles.size() == 2) check("t2_spacing", 64'(wd_cycles[1] - wd_cycles[0]), 64'(4));

      // T3: mid-word drop
      words_out.delete();
      beat(1, 8'h11); beat(1, 8'h22); beat(0, 8'h00);
      check("t3_gap_valid", 64'(valid_out), 64'(0));
      check("t3_hold", 64'(data_out), 64'(32'h05060708));
`ifdef CONV_8B_32B_ERR_EN
      check("t3_err", 64'(err_partial), 64'(1));
`endif
      beat(1, 8'h33); beat(1, 8'h44); beat(1, 8'h55); beat(1, 8'h66);
      check("t3_word", 64'(data_out), 64'(32'h33445566));
      check("t3_one_word", 64'(words_out.size()), 64'(1));

      // T4: async reset between beats 2 and 3
      beat(1, 8'h77); beat(1, 8'h88);
      @(negedge clk_4f);
      #2 reset_L = 1'b0;
      #1;
      check("t4_async_data", 64'(data_out), 64'(0));
      check("t4_async_valid", 64'(valid_out), 64'(0));
      check("t4_async_done", 64'(word_done), 64'(0));
      valid_in = 1'b0;
      @(negedge clk_4f); @(negedge clk_4f);
      reset_L = 1'b1;
      beat(1, 8'hA1); beat(1, 8'hA2); beat(1, 8'hA3); beat(1, 8'hA4);
      check("t4_word", 64'(data_out), 64'(32'hA1A2A3A4));

      // T5: idle after DEADBEEF
      send_word(32'hDEADBEEF);
      for (int i = 0; i < 10; i++) begin
         beat(0, 8'hFF);
         check("t5_hold", 64'(data_out), 64'(32'hDEADBEEF));
         check("t5_valid", 64'(valid_out), 64'(0));
         check("t5_done", 64'(word_done), 64'(0));
      end

      // T6: loopback from a serializer splitting words MSB first
      words_out.delete();
      send_word(32'h12345678);
      send_word(32'hCAFEF00D);
      check("t6_count", 64'(words_out.size()), 64'(2));
      if (words_out.size() == 2) begin
         check("t6_w0", 64'(words_out[0]), 64'(32'h12345678));
         check("t6_w1", 64'(words_out[1]), 64'(32'hCAFEF00D));
      end

      // Random beats with occasional gaps and resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            @(negedge clk_4f);
            reset_L = 1'b0;
            @(negedge clk_4f);
            reset_L = 1'b1;
         end
         beat($urandom_range(0, 99) < 85, 8'($urandom));
      end
      beat(0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
